// File: rtl/weight_slicer.sv
// Weight slicer: loads weights while idle, then streams them as LANES-wide beats with group masking.
// Optional stall counter enabled by defining WEIGHT_SLICER_STALL_CNT_EN.
module weight_slicer #(
  parameter int DWIDTH     = 8,
  parameter int GROUPS     = 4,
  parameter int NUM        = 4,
  parameter int WEIGHT_NUM = 64,
  localparam int LANES     = GROUPS * NUM,
  localparam int AW        = (WEIGHT_NUM > 1) ? $clog2(WEIGHT_NUM) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DWIDTH-1:0]         wr_data,
  input  logic                      enable,
  input  logic                      string_ready,
  input  logic [GROUPS-1:0]         grp_sel,
  output logic [LANES*DWIDTH-1:0]   weight_cut,
  output logic [LANES-1:0]          lane_mask,
  output logic                      weight_enable,
  input  logic                      weight_ready,
  output logic                      string_finish,
  output logic [15:0]               stall_cnt
);

  localparam int BEATS = (WEIGHT_NUM + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             ptr_q, ptr_d, load_ptr;
  logic [GROUPS-1:0]         grp_q, grp_d;
  logic                      valid_q, valid_d;
  logic                      finish_q, finish_d;
  logic [LANES*DWIDTH-1:0]   cut_q, cut_d, beat_cut;
  logic [LANES-1:0]          mask_q, mask_d, beat_mask;
  logic                      accept;
  logic [DWIDTH-1:0]         weight_mem [WEIGHT_NUM];

  // Storage is deliberately outside the reset domain so weights survive a reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && state_q == IDLE && int'(wr_addr) < WEIGHT_NUM)
      weight_mem[wr_addr] <= wr_data;
  end

  assign accept = valid_q & weight_ready;

  // On an accepting edge the beat being loaded is the next one.
  always_comb begin
    load_ptr = ptr_q;
    if (accept) load_ptr = ptr_q + BW'(1);
  end

  always_comb begin
    int idx;
    idx       = 0;
    beat_cut  = '0;
    beat_mask = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int n = 0; n < NUM; n++) begin
        idx = int'(load_ptr) * LANES + g * NUM + n;
        if (idx < WEIGHT_NUM && grp_q[g]) begin
          beat_cut[(g*NUM+n)*DWIDTH +: DWIDTH] = weight_mem[idx[AW-1:0]];
          beat_mask[g*NUM+n]                   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grp_d    = grp_q;
    valid_d  = valid_q;
    finish_d = 1'b0;
    cut_d    = cut_q;
    mask_d   = mask_q;
    case (state_q)
      IDLE: begin
        if (string_ready && enable) begin
          state_d = STREAM;
          grp_d   = grp_sel;
          ptr_d   = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (ptr_q == LAST_BEAT) begin
            state_d  = FINISH;
            valid_d  = 1'b0;
            finish_d = 1'b1;
          end else begin
            ptr_d   = load_ptr;
            valid_d = enable;
            if (enable) begin
              cut_d  = beat_cut;
              mask_d = beat_mask;
            end
          end
        end else if (!valid_q && enable) begin
          valid_d = 1'b1;
          cut_d   = beat_cut;
          mask_d  = beat_mask;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grp_q    <= '0;
      valid_q  <= 1'b0;
      finish_q <= 1'b0;
      cut_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grp_q    <= grp_d;
      valid_q  <= valid_d;
      finish_q <= finish_d;
      cut_q    <= cut_d;
      mask_q   <= mask_d;
    end
  end

  assign weight_cut    = cut_q;
  assign lane_mask     = mask_q;
  assign weight_enable = valid_q;
  assign string_finish = finish_q;

`ifdef WEIGHT_SLICER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && !weight_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_weight_slicer.sv
// Bench for weight_slicer (DWIDTH=8, GROUPS=2, NUM=2, WEIGHT_NUM=10): directed cases plus random traffic
// checked every cycle against a pass-level model.
module tb_weight_slicer;
  localparam int DW = 8, GR = 2, NM = 2, WN = 10, LN = 4, NB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        enable = 1'b0;
  logic        string_ready = 1'b0;
  logic [1:0]  grp_sel = '0;
  logic [31:0] weight_cut;
  logic [3:0]  lane_mask;
  logic        weight_enable;
  logic        weight_ready = 1'b1;
  logic        string_finish;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  weight_slicer #(.DWIDTH(DW), .GROUPS(GR), .NUM(NM), .WEIGHT_NUM(WN)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .enable(enable), .string_ready(string_ready), .grp_sel(grp_sel),
    .weight_cut(weight_cut), .lane_mask(lane_mask), .weight_enable(weight_enable),
    .weight_ready(weight_ready), .string_finish(string_finish), .stall_cnt(stall_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  // Model: weight table, pass phase (0 idle, 1 streaming, 2 finishing), beat index and expectations.
  logic [7:0]  wmem [16];
  int          m_phase = 0, m_beat = 0, m_stall = 0;
  bit          m_valid = 0, m_finish = 0;
  logic [1:0]  m_grp = '0;
  logic [31:0] acc_cut[$];
  logic [3:0]  acc_mask[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void exp_beat(input int b, input logic [1:0] g,
                                   output logic [31:0] c, output logic [3:0] m);
    c = '0;
    m = '0;
    for (int i = 0; i < LN; i++) begin
      int k = b * LN + i;
      if (k < WN && g[i / NM]) begin
        c = c | (32'(wmem[k[3:0]]) << (8 * i));
        m[i] = 1'b1;
      end
    end
  endfunction

  function automatic int exp_stall();
`ifdef WEIGHT_SLICER_STALL_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  // Compare at mid-cycle, then predict the effect of the coming edge from the current inputs.
  task automatic step();
    logic [31:0] ec;
    logic [3:0]  em;
    @(negedge clk);
    if (reset) begin
      chk("rst_cut", weight_cut, 0);
      chk("rst_mask", lane_mask, 0);
      chk("rst_valid", weight_enable, 0);
      chk("rst_finish", string_finish, 0);
      chk("rst_stall", stall_cnt, 0);
      m_phase = 0; m_beat = 0; m_valid = 0; m_finish = 0; m_stall = 0;
    end else begin
      chk("valid", weight_enable, m_valid);
      chk("finish", string_finish, m_finish);
      chk("stall", stall_cnt, exp_stall());
      if (m_valid) begin
        exp_beat(m_beat, m_grp, ec, em);
        chk("cut", weight_cut, ec);
        chk("mask", lane_mask, em);
        if (weight_ready) begin
          acc_cut.push_back(weight_cut);
          acc_mask.push_back(lane_mask);
        end
      end
      case (m_phase)
        0: begin
          m_finish = 0;
          if (wr_en && int'(wr_addr) < WN) wmem[wr_addr] = wr_data;
          if (string_ready && enable) begin
            m_phase = 1; m_beat = 0; m_valid = 0; m_grp = grp_sel;
          end
        end
        1: begin
          if (m_valid && weight_ready) begin
            if (m_beat == NB - 1) begin
              m_phase = 2; m_valid = 0; m_finish = 1;
            end else begin
              m_beat++;
              m_valid = enable;
            end
          end else if (m_valid) begin
            if (m_stall < 65535) m_stall++;
          end else if (enable) begin
            m_valid = 1;
          end
        end
        default: begin
          m_finish = 0;
          m_phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] g);
    grp_sel = g; string_ready = 1'b1; enable = 1'b1;
    step();
    string_ready = 1'b0;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 40 && m_phase != 0; i++) step();
    chk("pass_done", m_phase, 0);
  endtask

  task automatic wait_beat(input int b);
    for (int i = 0; i < 20 && !(m_valid && m_beat == b); i++) step();
    chk("beat_reached", m_beat, b);
  endtask

  int base;

  initial begin
    step();
    reset = 1'b0;
    step();

    for (int k = 0; k < WN; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = 8'(k + 1);
      step();
    end
    wr_en = 1'b0;

    // Full pass, all groups, back-to-back
    base = acc_cut.size();
    weight_ready = 1'b1;
    start(2'b11);
    run_to_idle();
    chk("b0_cut", acc_cut[base], 32'h04030201);   chk("b0_mask", acc_mask[base], 4'hF);
    chk("b1_cut", acc_cut[base+1], 32'h08070605); chk("b1_mask", acc_mask[base+1], 4'hF);
    chk("b2_cut", acc_cut[base+2], 32'h00000A09); chk("b2_mask", acc_mask[base+2], 4'h3);

    // Group 0 only
    base = acc_cut.size();
    start(2'b01);
    run_to_idle();
    chk("g01_b0_cut", acc_cut[base], 32'h00000201);   chk("g01_b0_mask", acc_mask[base], 4'h3);
    chk("g01_b2_cut", acc_cut[base+2], 32'h00000A09); chk("g01_b2_mask", acc_mask[base+2], 4'h3);

    // No groups selected still streams all beats
    base = acc_cut.size();
    start(2'b00);
    run_to_idle();
    chk("g00_beats", acc_cut.size() - base, NB);

    // Downstream stall on beat 1
    reset = 1'b1; step(); reset = 1'b0;
    base = acc_cut.size();
    start(2'b11);
    wait_beat(1);
    weight_ready = 1'b0;
    repeat (3) step();
    weight_ready = 1'b1;
    run_to_idle();
`ifdef WEIGHT_SLICER_STALL_CNT_EN
    chk("stall3", stall_cnt, 3);
`else
    chk("stall3", stall_cnt, 0);
`endif
    chk("stall_b1_cut", acc_cut[base+1], 32'h08070605);

    // Enable low for two cycles after beat 0 acceptance
    base = acc_cut.size();
    start(2'b11);
    wait_beat(0);
    enable = 1'b0;
    step();
    step();
    chk("pause_valid", weight_enable, 0);
    enable = 1'b1;
    run_to_idle();
    chk("pause_b1_cut", acc_cut[base+1], 32'h08070605);

    // Reset mid-pass, weights retained
    start(2'b11);
    wait_beat(1);
    weight_ready = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    weight_ready = 1'b1;
    base = acc_cut.size();
    start(2'b11);
    run_to_idle();
    chk("rst_b0_cut", acc_cut[base], 32'h04030201);

    // Writes while streaming are ignored
    start(2'b11);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    run_to_idle();
    base = acc_cut.size();
    start(2'b11);
    run_to_idle();
    chk("wr_ign_b0_cut", acc_cut[base], 32'h04030201);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      enable       = ($urandom % 4) != 0;
      weight_ready = ($urandom % 10) < 7;
      string_ready = ($urandom % 3) == 0;
      grp_sel      = 2'($urandom);
      wr_en        = ($urandom % 4) == 0;
      wr_addr      = 4'($urandom);
      wr_data      = 8'($urandom);
      reset        = ($urandom % 100) == 0;
      step();
    end
    reset = 1'b0; wr_en = 1'b0; string_ready = 1'b0; enable = 1'b1; weight_ready = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
